// File: rtl/inst_wb_if.sv
// inst_wb_if: memory-stage input, dbus read response and register-file write bundle for inst_wb
interface inst_wb_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  typedef struct packed {
    logic                      we;
    logic [REG_ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0]     wrdata;
  } reg_wreq_t;
  typedef struct packed {
    logic        read;
    logic [31:0] addr;
  } dcache_req_t;
  typedef struct packed {
    logic [2:0] mem_type;
  } decode_resp_t;
  typedef struct packed {
    logic         valid;
    reg_wreq_t    regs_wreq;
    dcache_req_t  dcache_req;
    decode_resp_t decode_resp;
  } pipe_mm_t;
  logic                  ready_i;
  logic                  ready_o;
  pipe_mm_t              pipe_mm;
  logic                  dbus_rvalid;
  logic [DATA_WIDTH-1:0] dbus_rddata;
  reg_wreq_t             regs_wreq;
  logic                  wb_valid;
  logic                  load_pending;
  modport master (
    output ready_i, pipe_mm, dbus_rvalid, dbus_rddata,
    input  ready_o, regs_wreq, wb_valid, load_pending
  );
  modport slave (
    input  ready_i, pipe_mm, dbus_rvalid, dbus_rddata,
    output ready_o, regs_wreq, wb_valid, load_pending
  );
endinterface

// File: rtl/inst_wb.sv
// inst_wb: MIPS write-back stage; waits for load data, aligns/merges it and registers the regfile write
module inst_wb #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic     clk,
  input logic     rst,
  inst_wb_if.slave wb
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LWL = 3'd5, LWR = 3'd6;
  logic [0:0]                state_q, state_d;
  logic                      buf_valid_q, buf_valid_d;
  logic [DATA_WIDTH-1:0]     buf_q, buf_d;
  logic                      wb_valid_q, wb_valid_d;
  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]     wrdata_q, wrdata_d;
  logic                      is_load, rdy, capture;
  logic [DATA_WIDTH-1:0]     rd, rt, lwl, lwr, ld;
  logic [1:0]                a;
  logic [2:0]                mt;
  logic [4:0]                sh;
  logic [7:0]                b;
  logic [15:0]               h;
  always_comb begin
    is_load = wb.pipe_mm.valid & wb.pipe_mm.dcache_req.read;
    rdy     = wb.ready_i & (((state_q == IDLE) & !is_load) | wb.dbus_rvalid | buf_valid_q);
    rd      = buf_valid_q ? buf_q : wb.dbus_rddata;
    rt      = wb.pipe_mm.regs_wreq.wrdata;
    a       = wb.pipe_mm.dcache_req.addr[1:0];
    mt      = wb.pipe_mm.decode_resp.mem_type;
    sh      = {a, 3'b000};
    b       = rd[sh +: 8];
    h       = a[1] ? rd[31:16] : rd[15:0];
    lwl     = (rd << {~a, 3'b000}) | (rt & (32'h00FF_FFFF >> sh));
    lwr     = (rd >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
    ld      = (mt == LB)  ? {{24{b[7]}}, b} :
              (mt == LBU) ? {24'b0, b} :
              (mt == LH)  ? {{16{h[15]}}, h} :
              (mt == LHU) ? {16'b0, h} :
              (mt == LWL) ? lwl :
              (mt == LWR) ? lwr : rd;
    // a response arriving while frozen is parked so it is not lost
    capture     = wb.dbus_rvalid & !wb.ready_i & !buf_valid_q & ((state_q == WAIT) | is_load);
    state_d     = rdy ? IDLE : (is_load & (state_q == IDLE)) ? WAIT : state_q;
    buf_valid_d = rdy ? 1'b0 : (capture | buf_valid_q);
    buf_d       = capture ? wb.dbus_rddata : buf_q;
    wb_valid_d  = rdy ? wb.pipe_mm.valid : wb.ready_i ? 1'b0 : wb_valid_q;
    we_d        = rdy ? (wb.pipe_mm.valid & wb.pipe_mm.regs_wreq.we & (|wb.pipe_mm.regs_wreq.waddr)) :
                  wb.ready_i ? 1'b0 : we_q;
    waddr_d     = rdy ? wb.pipe_mm.regs_wreq.waddr : waddr_q;
    wrdata_d    = rdy ? (is_load ? ld : rt) : wrdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
      wb_valid_q  <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      wb_valid_q  <= wb_valid_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wrdata_q    <= wrdata_d;
    end
  end
  assign wb.ready_o      = rdy;
  assign wb.regs_wreq    = {we_q, waddr_q, wrdata_q};
  assign wb.wb_valid     = wb_valid_q;
  assign wb.load_pending = (state_q == WAIT);
endmodule
